msg_sched: RTL and testbench

Round-robin scheduler that shares one 8-bit character sink (the simulation text/display channel) between NUM_REQ message producers. A producer owns the sink for a whole message, from first byte to the byte marked last. With escaping compiled in, the block converts non-printable bytes to C-style escape sequences on the fly, so any of the 256 byte values can be carried.

---
 rtl/msg_sched_pkg.sv | 19 +
 rtl/msg_sched_rr_arb.sv | 26 ++
 rtl/msg_sched.sv | 147 ++++++++++++++
 tb/tb_msg_sched.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/msg_sched_pkg.sv
// Shared types and helpers for the msg_sched character-sink scheduler.
package msg_sched_pkg;

  typedef enum logic [1:0] {IDLE, XFER, ESC} state_e;

  localparam logic [7:0] CHR_BSLASH = 8'h5C;
  localparam logic [7:0] CHR_QUOTE  = 8'h22;
  localparam logic [7:0] CHR_X      = 8'h78;

  // Printable ASCII passes through; quote and backslash must be escaped to stay unambiguous.
  function automatic logic needs_escape(input logic [7:0] b);
    return (b < 8'h20) || (b > 8'h7E) || (b == CHR_QUOTE) || (b == CHR_BSLASH);
  endfunction

  function automatic logic [7:0] hex_lc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

endpackage

// File: rtl/msg_sched_rr_arb.sv
// Combinational round-robin pick: first set request at or above ptr_i, wrapping.
module msg_sched_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int IW      = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  always_comb begin
    logic          found;
    logic [IW-1:0] idx;
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IW'((int'(ptr_i) + k) % NUM_REQ);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/msg_sched.sv
// Round-robin message scheduler onto one 8-bit sink; a grant covers a whole message.
// Define MSG_SCHED_ESCAPE_EN to expand non-printable bytes into C-style escape sequences.
module msg_sched
  import msg_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                 clk_ip,
  input  logic                 rst_n_ip,
  input  logic [NUM_REQ-1:0]   req_valid_ip,
  input  logic [NUM_REQ*8-1:0] req_data_ip,
  input  logic [NUM_REQ-1:0]   req_last_ip,
  output logic [NUM_REQ-1:0]   req_ready_op,
  output logic                 out_valid_op,
  output logic [7:0]           out_data_op,
  output logic                 out_last_op,
  input  logic                 out_ready_ip,
  output logic [NUM_REQ-1:0]   grant_op,
  output logic                 busy_op
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
`ifdef MSG_SCHED_ESCAPE_EN
  localparam bit ESC_EN = 1'b1;
`else
  localparam bit ESC_EN = 1'b0;
`endif

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d, gidx_q, gidx_d, arb_idx, ptr_inc;
  logic [NUM_REQ-1:0] arb_gnt;
  logic            ovld_q, ovld_d, olast_q, olast_d;
  logic [7:0]      odata_q, odata_d;
  logic [2:0][7:0] esc_q, esc_d;        // pending escape chars, [0] goes out next
  logic [1:0]      esc_cnt_q, esc_cnt_d;
  logic            esc_last_q, esc_last_d;
  logic            slot_free, take, in_last;
  logic [7:0]      in_byte;

  msg_sched_rr_arb #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
    .req_i (req_valid_ip),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt)
  );

  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (arb_gnt[i]) arb_idx = IW'(i);
  end

  assign slot_free = !ovld_q || out_ready_ip;
  assign in_byte   = req_data_ip[{gidx_q, 3'b000} +: 8];
  assign in_last   = req_last_ip[gidx_q];
  assign take      = (state_q == XFER) && slot_free && req_valid_ip[gidx_q];
  assign ptr_inc   = (gidx_q == IW'(NUM_REQ - 1)) ? '0 : gidx_q + IW'(1);

  always_ff @(posedge clk_ip or negedge rst_n_ip) begin
    if (!rst_n_ip) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      gidx_q     <= '0;
      ovld_q     <= 1'b0;
      odata_q    <= '0;
      olast_q    <= 1'b0;
      esc_q      <= '0;
      esc_cnt_q  <= '0;
      esc_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gidx_q     <= gidx_d;
      ovld_q     <= ovld_d;
      odata_q    <= odata_d;
      olast_q    <= olast_d;
      esc_q      <= esc_d;
      esc_cnt_q  <= esc_cnt_d;
      esc_last_q <= esc_last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gidx_d     = gidx_q;
    ovld_d     = ovld_q && !out_ready_ip;
    odata_d    = odata_q;
    olast_d    = olast_q;
    esc_d      = esc_q;
    esc_cnt_d  = esc_cnt_q;
    esc_last_d = esc_last_q;
    case (state_q)
      IDLE: if (|req_valid_ip) begin
        state_d = XFER;
        gidx_d  = arb_idx;
      end
      XFER: if (take) begin
        ovld_d     = 1'b1;
        esc_last_d = in_last;
        if (ESC_EN && needs_escape(in_byte)) begin
          odata_d = CHR_BSLASH;
          olast_d = 1'b0;
          state_d = ESC;
          if (in_byte == CHR_BSLASH || in_byte == CHR_QUOTE) begin
            esc_d     = {16'h0000, in_byte};
            esc_cnt_d = 2'd1;
          end else begin
            esc_d     = {hex_lc(in_byte[3:0]), hex_lc(in_byte[7:4]), CHR_X};
            esc_cnt_d = 2'd3;
          end
        end else begin
          odata_d = in_byte;
          olast_d = in_last;
          if (in_last) begin
            state_d = IDLE;
            ptr_d   = ptr_inc;
          end
        end
      end
      ESC: if (slot_free) begin
        ovld_d    = 1'b1;
        odata_d   = esc_q[0];
        esc_d     = {8'h00, esc_q[2:1]};
        esc_cnt_d = esc_cnt_q - 2'd1;
        olast_d   = esc_last_q && (esc_cnt_q == 2'd1);
        if (esc_cnt_q == 2'd1) begin
          state_d = esc_last_q ? IDLE : XFER;
          if (esc_last_q) ptr_d = ptr_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_op = '0;
    grant_op     = '0;
    busy_op      = (state_q != IDLE);
    if (state_q != IDLE) grant_op[gidx_q] = 1'b1;
    if (state_q == XFER) req_ready_op[gidx_q] = slot_free;
  end

  assign out_valid_op = ovld_q;
  assign out_data_op  = odata_q;
  assign out_last_op  = olast_q;

endmodule

// File: tb/tb_msg_sched.sv
// Directed bench for msg_sched: per-requester source queues, sink scoreboard of {char,last}.
module tb_msg_sched;
  localparam int NREQ = 4;

  logic              clk_ip = 1'b0;
  logic              rst_n_ip = 1'b0;
  logic [NREQ-1:0]   req_valid_ip = '0;
  logic [NREQ*8-1:0] req_data_ip = '0;
  logic [NREQ-1:0]   req_last_ip = '0;
  logic [NREQ-1:0]   req_ready_op;
  logic              out_valid_op;
  logic [7:0]        out_data_op;
  logic              out_last_op;
  logic              out_ready_ip = 1'b1;
  logic [NREQ-1:0]   grant_op;
  logic              busy_op;

  int errors = 0;
  int checks = 0;
  logic [8:0]      src_q [NREQ][$];
  logic [8:0]      exp_q [$];
  logic [NREQ-1:0] fire;
  string           hexs = "0123456789abcdef";

  msg_sched #(.NUM_REQ(NREQ)) dut (
    .clk_ip(clk_ip), .rst_n_ip(rst_n_ip),
    .req_valid_ip(req_valid_ip), .req_data_ip(req_data_ip), .req_last_ip(req_last_ip),
    .req_ready_op(req_ready_op),
    .out_valid_op(out_valid_op), .out_data_op(out_data_op), .out_last_op(out_last_op),
    .out_ready_ip(out_ready_ip), .grant_op(grant_op), .busy_op(busy_op)
  );

  always #5 clk_ip = ~clk_ip;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference expansion of one input byte into sink characters.
  task automatic exp_byte(input logic [7:0] b, input logic l);
`ifdef MSG_SCHED_ESCAPE_EN
    if (b == 8'h5C || b == 8'h22) begin
      exp_q.push_back({8'h5C, 1'b0});
      exp_q.push_back({b, l});
    end else if (b < 8'h20 || b > 8'h7E) begin
      exp_q.push_back({8'h5C, 1'b0});
      exp_q.push_back({8'h78, 1'b0});
      exp_q.push_back({hexs[b[7:4]], 1'b0});
      exp_q.push_back({hexs[b[3:0]], l});
    end else
      exp_q.push_back({b, l});
`else
    exp_q.push_back({b, l});
`endif
  endtask

  task automatic send(input int r, input logic [7:0] b, input logic l);
    src_q[r].push_back({b, l});
    exp_byte(b, l);
  endtask

  task automatic drive_heads();
    for (int i = 0; i < NREQ; i++) begin
      if (src_q[i].size() > 0) begin
        req_valid_ip[i]         = 1'b1;
        req_data_ip[i*8 +: 8]   = src_q[i][0][8:1];
        req_last_ip[i]          = src_q[i][0][0];
      end else begin
        req_valid_ip[i]         = 1'b0;
        req_data_ip[i*8 +: 8]   = 8'h00;
        req_last_ip[i]          = 1'b0;
      end
    end
  endtask

  // Handshakes are sampled on the falling edge, sources advance 1 time unit after the rising edge.
  task automatic tick();
    @(negedge clk_ip);
    fire = req_valid_ip & req_ready_op;
    @(posedge clk_ip);
    #1;
    for (int i = 0; i < NREQ; i++)
      if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    drive_heads();
  endtask

  function automatic bit src_pending();
    for (int i = 0; i < NREQ; i++)
      if (src_q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || busy_op || src_pending()) && n < 300) begin
      tick();
      n++;
    end
    checks++;
    assert (n < 300) else begin
      errors++;
      $error("FAIL %s timeout pending=%0d expected=0", tag, exp_q.size());
    end
  endtask

  task automatic flush();
    for (int i = 0; i < NREQ; i++) src_q[i].delete();
    exp_q.delete();
    drive_heads();
  endtask

  always @(negedge clk_ip) begin
    if (rst_n_ip && out_valid_op && out_ready_ip) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL sink_extra observed=%0h expected=none", {out_data_op, out_last_op});
      end
      if (exp_q.size() > 0) chk("sink_char", {23'd0, out_data_op, out_last_op}, {23'd0, exp_q.pop_front()});
    end
  end

  initial begin
    int n;
    // Reset state
    repeat (3) tick();
    chk("rst_valid", out_valid_op, 0);
    chk("rst_data",  out_data_op, 0);
    chk("rst_grant", grant_op, 0);
    chk("rst_busy",  busy_op, 0);
    chk("rst_ready", req_ready_op, 0);

    // Single requester "AB"
    send(0, 8'h41, 1'b0);
    send(0, 8'h42, 1'b1);
    drive_heads();
    rst_n_ip = 1'b1;
    tick();
    chk("ab_grant", grant_op, 4'b0001);
    chk("ab_busy",  busy_op, 1);
    chk("ab_ready", req_ready_op, 4'b0001);
    tick();
    chk("ab_first", {out_valid_op, out_data_op}, {1'b1, 8'h41});
    tick();
    chk("ab_last",    {out_data_op, out_last_op}, {8'h42, 1'b1});
    chk("ab_gnt_clr", grant_op, 0);
    wait_idle("ab_drain");

    // Requesters 1 and 3 valid at reset release, then again with pointer back at 0
    rst_n_ip = 1'b0;
    tick();
    send(1, 8'h31, 1'b0); send(1, 8'h32, 1'b1);
    send(3, 8'h33, 1'b0); send(3, 8'h34, 1'b1);
    drive_heads();
    rst_n_ip = 1'b1;
    tick();
    chk("rr_first", grant_op, 4'b0010);
    wait_idle("rr_drain1");
    send(1, 8'h35, 1'b1);
    send(3, 8'h36, 1'b1);
    drive_heads();
    tick();
    chk("rr_again", grant_op, 4'b0010);
    wait_idle("rr_drain2");

    // Back-pressure mid-message
    send(2, 8'h77, 1'b0); send(2, 8'h78, 1'b0);
    send(2, 8'h79, 1'b0); send(2, 8'h7A, 1'b1);
    drive_heads();
    repeat (3) tick();
    out_ready_ip = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_hold",  {out_valid_op, out_data_op}, {1'b1, 8'h78});
      chk("bp_ready", req_ready_op, 0);
    end
    out_ready_ip = 1'b1;
    wait_idle("bp_drain");

    // Escape expansion (or pass-through in the default build)
    send(0, 8'h01, 1'b0); send(0, 8'h5C, 1'b0); send(0, 8'hFF, 1'b1);
    drive_heads();
    wait_idle("esc_drain");

    // Reset in the middle of a message
    send(1, 8'h80, 1'b0); send(1, 8'h81, 1'b0); send(1, 8'h82, 1'b1);
    drive_heads();
    n = 0;
    while (!(out_valid_op && out_data_op == 8'h5C) && !(out_valid_op && out_data_op == 8'h80) && n < 20) begin
      tick();
      n++;
    end
    checks++;
    assert (n < 20) else begin
      errors++;
      $error("FAIL mid_start timeout observed=%0d expected=<20", n);
    end
    tick();
    rst_n_ip = 1'b0;
    #1;
    chk("mid_valid", out_valid_op, 0);
    chk("mid_data",  out_data_op, 0);
    chk("mid_last",  out_last_op, 0);
    chk("mid_grant", grant_op, 0);
    chk("mid_busy",  busy_op, 0);
    chk("mid_ready", req_ready_op, 0);
    flush();
    send(0, 8'h51, 1'b1);
    send(3, 8'h52, 1'b1);
    drive_heads();
    tick();
    rst_n_ip = 1'b1;
    tick();
    chk("mid_rr0", grant_op, 4'b0001);
    wait_idle("mid_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
